uart_fifo: RTL and testbench

- Parametrised successor to the fixed 115.2k/8N1 single-buffer UART.
- Clock-derived bit timing, configurable data width and parity, and Rx/Tx FIFOs, so SW can post and drain bursts without per-byte polling.
- Sits on the SOC CSR bus next to the timer; serial pins go straight to the board.

---
 rtl/uart_fifo.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_uart_fifo.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo.sv
// uart_fifo: UART with clock-derived bit timing, configurable data width and
// parity, and show-ahead Tx/Rx FIFOs.
//
// Ports
//   clk, arst_n        system clock, asynchronous active-low reset
//   uart_rx / uart_tx  serial line in (asynchronous) / out (idle high)
//   tx_write, tx_data  push a character into the Tx FIFO
//   tx_full, tx_level  Tx FIFO full flag and occupancy
//   tx_busy            Tx FIFO non-empty or a frame still on the wire
//   rx_read            pop the Rx FIFO head
//   rx_valid           Rx FIFO non-empty
//   rx_data/perr/ferr  Rx FIFO head entry and its error flags
//   rx_level           Rx FIFO occupancy
//   rx_oflow/_clr      sticky overflow flag and its clear
//
// Handshakes: a Tx transfer happens on a clock edge where tx_write=1 and
// tx_full=0; an Rx transfer happens on a clock edge where rx_read=1 and
// rx_valid=1. Requests outside those conditions are ignored.
//
// Frame: START(0), DATA_BITS data bits LSB first, optional parity, STOP(1);
// every bit lasts BIT_CYC clocks.

module uart_fifo #(
  parameter int CLK_HZ    = 27000000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int TX_DEPTH  = 16,
  parameter int RX_DEPTH  = 16
) (
  input  logic                           clk,
  input  logic                           arst_n,
  input  logic                           uart_rx,
  output logic                           uart_tx,
  input  logic                           tx_write,
  input  logic [DATA_BITS-1:0]           tx_data,
  output logic                           tx_full,
  output logic [$clog2(TX_DEPTH+1)-1:0]  tx_level,
  output logic                           tx_busy,
  input  logic                           rx_read,
  output logic                           rx_valid,
  output logic [DATA_BITS-1:0]           rx_data,
  output logic                           rx_perr,
  output logic                           rx_ferr,
  output logic [$clog2(RX_DEPTH+1)-1:0]  rx_level,
  output logic                           rx_oflow,
  input  logic                           rx_oflow_clr
);

  localparam int BIT_CYC = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int CW      = $clog2(BIT_CYC);
  localparam int IW      = $clog2(DATA_BITS);
  localparam int TAW     = $clog2(TX_DEPTH);
  localparam int RAW     = $clog2(RX_DEPTH);
  localparam int RW      = DATA_BITS + 2;

  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] CYC_HALF = CW'(BIT_CYC / 2 - 1);
  localparam logic [IW-1:0] BIT_LAST = IW'(DATA_BITS - 1);
  localparam logic          PAR_EN   = (PARITY != 0);
  localparam logic          PAR_INV  = (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } uart_state_e;

  // ---------------------------------------------------------------------
  // Tx FIFO
  // ---------------------------------------------------------------------
  logic [DATA_BITS-1:0] tx_mem [TX_DEPTH];
  logic [TAW:0]         tx_wr_ptr, tx_rd_ptr;
  logic                 tx_empty, tx_push, tx_pop;

  assign tx_empty = (tx_wr_ptr == tx_rd_ptr);
  assign tx_full  = (tx_wr_ptr[TAW] != tx_rd_ptr[TAW]) &&
                    (tx_wr_ptr[TAW-1:0] == tx_rd_ptr[TAW-1:0]);
  // A write while full is dropped even if the FSM pops in the same cycle.
  assign tx_push  = tx_write && !tx_full;
  assign tx_level = tx_wr_ptr - tx_rd_ptr;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr[TAW-1:0]] <= tx_data;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Tx FSM
  // ---------------------------------------------------------------------
  uart_state_e          tx_state, tx_state_nxt;
  logic [CW-1:0]        tx_cnt;
  logic [IW-1:0]        tx_idx;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_par;
  logic                 tx_busy_q;
  logic                 tx_tick;
  logic                 tx_line;

  assign tx_tick = (tx_cnt == CYC_LAST);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      tx_state  <= S_IDLE;
      tx_cnt    <= '0;
      tx_idx    <= '0;
      tx_shift  <= '0;
      tx_par    <= 1'b0;
      tx_busy_q <= 1'b0;
    end else begin
      tx_state  <= tx_state_nxt;
      tx_busy_q <= (tx_state != S_IDLE);
      if (tx_pop) begin
        tx_shift <= tx_mem[tx_rd_ptr[TAW-1:0]];
        tx_par   <= (^tx_mem[tx_rd_ptr[TAW-1:0]]) ^ PAR_INV;
        tx_cnt   <= '0;
        tx_idx   <= '0;
      end else if (tx_state != S_IDLE) begin
        tx_cnt <= tx_tick ? '0 : tx_cnt + 1'b1;
        if (tx_state == S_DATA && tx_tick) begin
          tx_shift <= tx_shift >> 1;
          tx_idx   <= tx_idx + 1'b1;
        end
      end
    end
  end

  always_comb begin
    tx_state_nxt = tx_state;
    case (tx_state)
      S_IDLE:   if (!tx_empty) tx_state_nxt = S_START;
      S_START:  if (tx_tick) tx_state_nxt = S_DATA;
      S_DATA:   if (tx_tick && tx_idx == BIT_LAST)
                  tx_state_nxt = PAR_EN ? S_PARITY : S_STOP;
      S_PARITY: if (tx_tick) tx_state_nxt = S_STOP;
      S_STOP:   if (tx_tick) tx_state_nxt = S_IDLE;
      default:  tx_state_nxt = S_IDLE;
    endcase
  end

  // The FSM always spends one cycle in IDLE between frames, which is what
  // stretches the inter-frame stop level to BIT_CYC+1 clocks.
  assign tx_pop = (tx_state == S_IDLE) && !tx_empty;

  always_comb begin
    tx_line = 1'b1;
    case (tx_state)
      S_START:  tx_line = 1'b0;
      S_DATA:   tx_line = tx_shift[0];
      S_PARITY: tx_line = tx_par;
      default:  tx_line = 1'b1;
    endcase
  end

  // Registered pin: line level trails the state by one clock, hence the
  // write-to-falling-edge latency of two clocks.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) uart_tx <= 1'b1;
    else         uart_tx <= tx_line;
  end

  // tx_busy_q covers the final clock of the stop bit still on the pin.
  assign tx_busy = !tx_empty || (tx_state != S_IDLE) || tx_busy_q;

  // ---------------------------------------------------------------------
  // Rx synchroniser and FSM
  // ---------------------------------------------------------------------
  logic [1:0]           rx_sync;
  logic                 rx_line, rx_line_q;
  uart_state_e          rx_state, rx_state_nxt;
  logic [CW-1:0]        rx_cnt;
  logic [IW-1:0]        rx_idx;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_par_bit;
  logic                 rx_tick, rx_half, rx_fall;
  logic                 rx_push_req;
  logic [RW-1:0]        rx_entry;

  assign rx_line = rx_sync[1];
  assign rx_tick = (rx_cnt == CYC_LAST);
  assign rx_half = (rx_cnt == CYC_HALF);
  // Edge detection needs a 1 then a 0, so a line held low after a framing
  // error (break) cannot re-trigger until it has returned high.
  assign rx_fall = rx_line_q && !rx_line;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rx_sync   <= 2'b11;
      rx_line_q <= 1'b1;
    end else begin
      rx_sync   <= {rx_sync[0], uart_rx};
      rx_line_q <= rx_line;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rx_state   <= S_IDLE;
      rx_cnt     <= '0;
      rx_idx     <= '0;
      rx_shift   <= '0;
      rx_par_bit <= 1'b0;
    end else begin
      rx_state <= rx_state_nxt;
      if (rx_state == S_IDLE || (rx_state == S_START && rx_half) || rx_tick)
        rx_cnt <= '0;
      else
        rx_cnt <= rx_cnt + 1'b1;
      if (rx_state == S_IDLE) rx_idx <= '0;
      if (rx_state == S_DATA && rx_tick) begin
        rx_shift <= {rx_line, rx_shift[DATA_BITS-1:1]};
        rx_idx   <= rx_idx + 1'b1;
      end
      if (rx_state == S_PARITY && rx_tick) rx_par_bit <= rx_line;
    end
  end

  always_comb begin
    rx_state_nxt = rx_state;
    case (rx_state)
      S_IDLE:   if (rx_fall) rx_state_nxt = S_START;
      S_START:  if (rx_half) rx_state_nxt = rx_line ? S_IDLE : S_DATA;
      S_DATA:   if (rx_tick && rx_idx == BIT_LAST)
                  rx_state_nxt = PAR_EN ? S_PARITY : S_STOP;
      S_PARITY: if (rx_tick) rx_state_nxt = S_STOP;
      S_STOP:   if (rx_tick) rx_state_nxt = S_IDLE;
      default:  rx_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    rx_push_req = (rx_state == S_STOP) && rx_tick;
    rx_entry    = {!rx_line,
                   PAR_EN && (rx_par_bit != ((^rx_shift) ^ PAR_INV)),
                   rx_shift};
  end

  // ---------------------------------------------------------------------
  // Rx FIFO with registered show-ahead head
  // ---------------------------------------------------------------------
  logic [RW-1:0] rx_mem [RX_DEPTH];
  logic [RAW:0]  rx_wr_ptr, rx_rd_ptr, rx_wr_nxt, rx_rd_nxt;
  logic          rx_empty, rx_full, rx_pop, rx_push;
  logic [RW-1:0] rx_head;

  assign rx_empty  = (rx_wr_ptr == rx_rd_ptr);
  assign rx_full   = (rx_wr_ptr[RAW] != rx_rd_ptr[RAW]) &&
                     (rx_wr_ptr[RAW-1:0] == rx_rd_ptr[RAW-1:0]);
  assign rx_pop    = rx_read && !rx_empty;
  assign rx_push   = rx_push_req && (!rx_full || rx_pop);
  assign rx_wr_nxt = rx_wr_ptr + (RAW+1)'(rx_push);
  assign rx_rd_nxt = rx_rd_ptr + (RAW+1)'(rx_pop);

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr[RAW-1:0]] <= rx_entry;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_head   <= '0;
      rx_oflow  <= 1'b0;
    end else begin
      rx_wr_ptr <= rx_wr_nxt;
      rx_rd_ptr <= rx_rd_nxt;
      // Head follows the next read slot; when that slot is being written in
      // this same cycle the incoming entry is forwarded. An empty FIFO holds
      // the last head value.
      if (rx_wr_nxt != rx_rd_nxt) begin
        if (rx_push && rx_wr_ptr[RAW-1:0] == rx_rd_nxt[RAW-1:0])
          rx_head <= rx_entry;
        else
          rx_head <= rx_mem[rx_rd_nxt[RAW-1:0]];
      end
      // Hardware set wins over a simultaneous clear.
      if (rx_push_req && !rx_push) rx_oflow <= 1'b1;
      else if (rx_oflow_clr)       rx_oflow <= 1'b0;
    end
  end

  assign rx_valid = !rx_empty;
  assign rx_level = rx_wr_ptr - rx_rd_ptr;
  assign rx_data  = rx_head[DATA_BITS-1:0];
  assign rx_perr  = rx_head[DATA_BITS];
  assign rx_ferr  = rx_head[DATA_BITS+1];

endmodule

// File: tb/tb_uart_fifo.sv
// Testbench for uart_fifo. Two instances: an 8N1 unit (BIT_CYC=16, depth 16)
// and a 7-bit odd-parity unit (BIT_CYC=16, depth 4).

module tb_uart_fifo;

  localparam int BC = 16;

  // ---------------- clock / reset ----------------
  logic clk;
  logic arst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- 8N1 instance ----------------
  logic       rx_drv, loop_en;
  logic       uart_rx, uart_tx;
  logic       tx_write, tx_full, tx_busy;
  logic [7:0] tx_data;
  logic [4:0] tx_level, rx_level;
  logic       rx_read, rx_valid, rx_perr, rx_ferr, rx_oflow, rx_oflow_clr;
  logic [7:0] rx_data;

  assign uart_rx = loop_en ? uart_tx : rx_drv;

  uart_fifo #(.CLK_HZ(160), .BAUD(10), .DATA_BITS(8), .PARITY(0),
              .TX_DEPTH(16), .RX_DEPTH(16)) u_dut (
    .clk(clk), .arst_n(arst_n), .uart_rx(uart_rx), .uart_tx(uart_tx),
    .tx_write(tx_write), .tx_data(tx_data), .tx_full(tx_full),
    .tx_level(tx_level), .tx_busy(tx_busy), .rx_read(rx_read),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_perr(rx_perr),
    .rx_ferr(rx_ferr), .rx_level(rx_level), .rx_oflow(rx_oflow),
    .rx_oflow_clr(rx_oflow_clr)
  );

  // ---------------- 7O1 instance ----------------
  logic       p_rx_drv, p_loop;
  logic       p_uart_rx, p_uart_tx;
  logic       p_tx_write, p_tx_full, p_tx_busy;
  logic [6:0] p_tx_data, p_rx_data;
  logic [2:0] p_tx_level, p_rx_level;
  logic       p_rx_read, p_rx_valid, p_rx_perr, p_rx_ferr, p_rx_oflow, p_rx_oflow_clr;

  assign p_uart_rx = p_loop ? p_uart_tx : p_rx_drv;

  uart_fifo #(.CLK_HZ(160), .BAUD(10), .DATA_BITS(7), .PARITY(2),
              .TX_DEPTH(4), .RX_DEPTH(4)) u_par (
    .clk(clk), .arst_n(arst_n), .uart_rx(p_uart_rx), .uart_tx(p_uart_tx),
    .tx_write(p_tx_write), .tx_data(p_tx_data), .tx_full(p_tx_full),
    .tx_level(p_tx_level), .tx_busy(p_tx_busy), .rx_read(p_rx_read),
    .rx_valid(p_rx_valid), .rx_data(p_rx_data), .rx_perr(p_rx_perr),
    .rx_ferr(p_rx_ferr), .rx_level(p_rx_level), .rx_oflow(p_rx_oflow),
    .rx_oflow_clr(p_rx_oflow_clr)
  );

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Falling edges seen on the 8N1 serial output.
  logic tx_prev = 1'b1;
  int   fall_cnt = 0;
  always @(negedge clk) begin
    if (tx_prev && !uart_tx) fall_cnt++;
    tx_prev = uart_tx;
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end 1 ns after a rising edge.
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rx_bit(input int sel, input logic v);
    if (sel == 0) rx_drv = v;
    else          p_rx_drv = v;
    cycles(BC);
  endtask

  task automatic drive_frame(input int sel, input logic [7:0] d, input int nbits,
                             input logic has_par, input logic par, input logic stop);
    rx_bit(sel, 1'b0);
    for (int i = 0; i < nbits; i++) rx_bit(sel, d[i]);
    if (has_par) rx_bit(sel, par);
    rx_bit(sel, stop);
  endtask

  task automatic pop_main(input string tag);
    check({tag, "_valid"}, rx_valid, 1);
    check({tag, "_data"}, rx_data, exp_q.pop_front());
    check({tag, "_perr"}, rx_perr, 0);
    check({tag, "_ferr"}, rx_ferr, 0);
    rx_read = 1'b1;
    cycles(1);
    rx_read = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] b;
    int         gap;
    int         base;

    arst_n = 1'b0;
    rx_drv = 1'b1; loop_en = 1'b0; tx_write = 1'b0; tx_data = '0;
    rx_read = 1'b0; rx_oflow_clr = 1'b0;
    p_rx_drv = 1'b1; p_loop = 1'b0; p_tx_write = 1'b0; p_tx_data = '0;
    p_rx_read = 1'b0; p_rx_oflow_clr = 1'b0;
    cycles(3);

    // Reset values
    check("rst_uart_tx", uart_tx, 1);
    check("rst_tx_flags", {tx_full, tx_busy, rx_valid, rx_oflow}, 0);
    check("rst_levels", {tx_level, rx_level}, 0);
    check("rst_head", {rx_ferr, rx_perr, rx_data}, 0);
    arst_n = 1'b1;
    cycles(2);

    // ---- Tx frame 0xA5, 8N1 ----
    tx_write = 1'b1; tx_data = 8'hA5;
    cycles(1);                       // write edge N
    tx_write = 1'b0;
    check("tx_level_push", tx_level, 1);
    check("tx_busy_push", tx_busy, 1);
    cycles(1);                       // N+1
    check("tx_pre_fall", uart_tx, 1);
    check("tx_level_pop", tx_level, 0);
    cycles(1);                       // N+2
    check("tx_fall", uart_tx, 0);
    cycles(8);
    check("tx_start_mid", uart_tx, 0);
    b = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      cycles(BC);
      check("tx_bit", uart_tx, b[i]);
    end
    cycles(BC);
    check("tx_stop_mid", uart_tx, 1);
    cycles(7);                       // last clock of the stop bit
    check("tx_busy_stop", tx_busy, 1);
    cycles(1);
    check("tx_busy_fall", tx_busy, 0);
    check("tx_idle", uart_tx, 1);

    // ---- Loopback burst 0x00, 0xFF, 0x55 ----
    loop_en = 1'b1;
    tx_write = 1'b1;
    tx_data = 8'h00; exp_q.push_back(8'h00); cycles(1);
    tx_data = 8'hFF; exp_q.push_back(8'hFF); cycles(1);
    tx_data = 8'h55; exp_q.push_back(8'h55); cycles(1);
    tx_write = 1'b0;
    for (int k = 0; k < 20 && uart_tx; k++) cycles(1);
    for (int k = 0; k < 300 && !uart_tx; k++) cycles(1);
    gap = 0;
    for (int k = 0; k < 100 && uart_tx; k++) begin
      gap++;
      cycles(1);
    end
    check("lb_gap", gap, BC + 1);
    for (int k = 0; k < 800 && rx_level != 3; k++) cycles(1);
    check("lb_level", rx_level, 3);
    for (int i = 0; i < 3; i++) pop_main("lb_pop");
    check("lb_empty", {rx_valid, rx_level}, 0);
    check("lb_hold", rx_data, 8'h55);
    cycles(20);
    loop_en = 1'b0;

    // ---- 7O1: transmitted parity bit and loopback of 0x41 ----
    p_loop = 1'b1;
    p_tx_write = 1'b1; p_tx_data = 7'h41;
    cycles(1);
    p_tx_write = 1'b0;
    cycles(2);
    check("par_tx_fall", p_uart_tx, 0);
    cycles(8 + BC * 7);              // middle of last data bit
    check("par_tx_b6", p_uart_tx, 1);
    cycles(BC);
    check("par_tx_pbit", p_uart_tx, 1);
    cycles(BC);
    check("par_tx_stop", p_uart_tx, 1);
    for (int k = 0; k < 50 && p_rx_level != 1; k++) cycles(1);
    check("par_lb_level", p_rx_level, 1);
    check("par_lb_entry", {p_rx_ferr, p_rx_perr, p_rx_data}, {2'b00, 7'h41});
    p_rx_read = 1'b1; cycles(1); p_rx_read = 1'b0;
    cycles(20);
    p_loop = 1'b0;

    // Wrong parity bit (0), then correct one (1)
    drive_frame(1, 8'h41, 7, 1'b1, 1'b0, 1'b1);
    cycles(2);
    check("par_bad_level", p_rx_level, 1);
    check("par_bad_entry", {p_rx_ferr, p_rx_perr, p_rx_data}, {2'b01, 7'h41});
    p_rx_read = 1'b1; cycles(1); p_rx_read = 1'b0;
    drive_frame(1, 8'h41, 7, 1'b1, 1'b1, 1'b1);
    cycles(2);
    check("par_good_entry", {p_rx_ferr, p_rx_perr, p_rx_data}, {2'b00, 7'h41});
    p_rx_read = 1'b1; cycles(1); p_rx_read = 1'b0;
    check("par_empty", p_rx_valid, 0);

    // ---- Rx overflow: 18 frames, no reads ----
    for (int i = 0; i < 18; i++) begin
      drive_frame(0, 8'(8'h10 + i), 8, 1'b0, 1'b0, 1'b1);
      if (i < 16) exp_q.push_back(8'(8'h10 + i));
    end
    cycles(2);
    check("of_level", rx_level, 16);
    check("of_flag", rx_oflow, 1);
    rx_oflow_clr = 1'b1; cycles(1); rx_oflow_clr = 1'b0;
    check("of_clr", rx_oflow, 0);
    check("of_head", rx_data, exp_q.pop_front());
    // Push while full, with rx_read on the push edge (155 clocks after the
    // start bit is applied: 2 sync + 8 half bit + 9 x 16 bit centres + 1).
    fork
      drive_frame(0, 8'h77, 8, 1'b0, 1'b0, 1'b1);
      begin
        repeat (154) @(posedge clk);
        #1 rx_read = 1'b1;
        cycles(1);
        rx_read = 1'b0;
      end
    join
    exp_q.push_back(8'h77);
    cycles(2);
    check("of_coinc_level", rx_level, 16);
    check("of_coinc_flag", rx_oflow, 0);
    for (int i = 0; i < 16; i++) pop_main("of_pop");
    check("of_drained", rx_level, 0);

    // ---- False start glitch, then framing error with break ----
    rx_drv = 1'b0; cycles(6); rx_drv = 1'b1;
    cycles(40);
    check("glitch_level", {rx_valid, rx_level}, 0);
    drive_frame(0, 8'h3C, 8, 1'b0, 1'b0, 1'b1);
    exp_q.push_back(8'h3C);
    cycles(2);
    check("post_glitch_level", rx_level, 1);
    pop_main("post_glitch");
    drive_frame(0, 8'hC3, 8, 1'b0, 1'b0, 1'b0);
    cycles(40);
    rx_drv = 1'b1;
    cycles(40);
    check("brk_level", rx_level, 1);
    check("brk_entry", {rx_ferr, rx_perr, rx_data}, {2'b10, 8'hC3});
    rx_read = 1'b1; cycles(1); rx_read = 1'b0;
    check("brk_no_second", rx_level, 0);

    // ---- Fill Tx FIFO ----
    base = fall_cnt;
    tx_write = 1'b1; tx_data = 8'hFF;
    cycles(17);                      // 17 accepted: one popped by the FSM
    tx_write = 1'b0;
    check("txf_full", tx_full, 1);
    check("txf_level", tx_level, 16);
    tx_write = 1'b1; tx_data = 8'h00;
    cycles(1);
    tx_write = 1'b0;
    check("txf_drop", tx_level, 16);
    for (int k = 0; k < 3200 && tx_busy; k++) cycles(1);
    check("txf_done", tx_busy, 0);
    check("txf_frames", fall_cnt - base, 17);

    // ---- Reset mid-frame ----
    tx_write = 1'b1; tx_data = 8'h00;
    cycles(3);
    tx_write = 1'b0;
    cycles(40);
    check("rst_pre_tx", uart_tx, 0);
    check("rst_pre_level", tx_level, 2);
    #2 arst_n = 1'b0;
    #1;
    check("rst_async_tx", uart_tx, 1);
    check("rst_async_level", tx_level, 0);
    check("rst_async_busy", tx_busy, 0);
    @(posedge clk);
    #1 arst_n = 1'b1;
    cycles(20);
    check("rst_after_tx", uart_tx, 1);
    check("rst_after_level", {tx_busy, tx_level}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
